// File: rtl/apb_arbiter_pkg.sv
// Shared types and constants for the two-requester APB arbiter.
// Holds the transfer state encoding and the default completion timeout.
package apb_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   localparam int unsigned DEFAULT_TIMEOUT = 1024;

   // Width able to hold 0..t; a disabled timeout still gets a 1-bit counter.
   function automatic int unsigned counterWidth(input int unsigned t);
      return (t == 0) ? 1 : $clog2(t + 1);
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin selector: on a tie, picks the requester not granted last.
// A lone requester always wins; the output is don't-care when nobody requests.
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt_id
);

   always_comb begin
      gnt_id = 1'b0;
      if (req == 2'b11) begin
         gnt_id = ~last;
      end else if (req[1]) begin
         gnt_id = 1'b1;
      end
   end

endmodule

// File: rtl/apb_arbiter2.sv
// Two-requester APB arbiter in front of a single completer port, with
// round-robin grant and an optional forced-error timeout in ACCESS.
module apb_arbiter2
   import apb_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic        clock,
   input  logic        reset,

   input  logic [31:0] in0_paddr,
   input  logic        in0_psel,
   input  logic        in0_penable,
   input  logic [2:0]  in0_pprot,
   input  logic        in0_pwrite,
   input  logic [31:0] in0_pwdata,
   input  logic [3:0]  in0_pstrb,
   output logic        in0_pready,
   output logic [31:0] in0_prdata,
   output logic        in0_pslverr,

   input  logic [31:0] in1_paddr,
   input  logic        in1_psel,
   input  logic        in1_penable,
   input  logic [2:0]  in1_pprot,
   input  logic        in1_pwrite,
   input  logic [31:0] in1_pwdata,
   input  logic [3:0]  in1_pstrb,
   output logic        in1_pready,
   output logic [31:0] in1_prdata,
   output logic        in1_pslverr,

   output logic [31:0] out_paddr,
   output logic        out_psel,
   output logic        out_penable,
   output logic [2:0]  out_pprot,
   output logic        out_pwrite,
   output logic [31:0] out_pwdata,
   output logic [3:0]  out_pstrb,
   input  logic        out_pready,
   input  logic [31:0] out_prdata,
   input  logic        out_pslverr,

   output logic        grant_id
);

   localparam int unsigned CW = counterWidth(TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
   localparam bit TO_ENABLED = (TIMEOUT > 0);

   state_t        r_state;
   state_t        w_nextState;
   logic          r_grantId;
   logic          r_last;
   logic [31:0]   r_paddr;
   logic [2:0]    r_pprot;
   logic          r_pwrite;
   logic [31:0]   r_pwdata;
   logic [3:0]    r_pstrb;
   logic [CW-1:0] r_count;

   logic          w_gnt;
   logic          w_anyReq;
   logic          w_access;
   logic          w_timeout;
   logic          w_done;
   logic [31:0]   w_rspData;
   logic          w_rspErr;
   logic          w_unusedPenable;

   // Requesters' penable carries no information the arbiter needs.
   assign w_unusedPenable = in0_penable ^ in1_penable;

   assign w_anyReq  = in0_psel | in1_psel;
   assign w_access  = (r_state == ACCESS);
   assign w_timeout = TO_ENABLED && w_access && !out_pready && (r_count == TO_LAST);
   assign w_done    = w_access && (out_pready || w_timeout);

   rr_arbiter2 u_rr (
      .req    ({in1_psel, in0_psel}),
      .last   (r_last),
      .gnt_id (w_gnt)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_anyReq) w_nextState = SETUP;
         SETUP:   w_nextState = ACCESS;
         ACCESS:  if (w_done) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // The last-grant pointer moves only here, at grant time.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_grantId <= 1'b0;
         r_last    <= 1'b1;
         r_paddr   <= '0;
         r_pprot   <= '0;
         r_pwrite  <= 1'b0;
         r_pwdata  <= '0;
         r_pstrb   <= '0;
      end else if ((r_state == IDLE) && w_anyReq) begin
         r_grantId <= w_gnt;
         r_last    <= w_gnt;
         r_paddr   <= w_gnt ? in1_paddr  : in0_paddr;
         r_pprot   <= w_gnt ? in1_pprot  : in0_pprot;
         r_pwrite  <= w_gnt ? in1_pwrite : in0_pwrite;
         r_pwdata  <= w_gnt ? in1_pwdata : in0_pwdata;
         r_pstrb   <= w_gnt ? in1_pstrb  : in0_pstrb;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (r_state == SETUP) begin
         r_count <= '0;
      end else if (w_access && !out_pready && (r_count != CNT_MAX)) begin
         r_count <= r_count + CW'(1);
      end
   end

   assign out_psel    = (r_state != IDLE);
   assign out_penable = w_access;
   assign out_paddr   = r_paddr;
   assign out_pprot   = r_pprot;
   assign out_pwrite  = r_pwrite;
   assign out_pwdata  = r_pwdata;
   assign out_pstrb   = r_pstrb;
   assign grant_id    = r_grantId;

   // A real completer response wins over a coincident timeout.
   assign w_rspData = out_pready ? out_prdata : 32'h0;
   assign w_rspErr  = out_pready ? out_pslverr : 1'b1;

   always_comb begin
      in0_pready  = 1'b0;
      in0_prdata  = 32'h0;
      in0_pslverr = 1'b0;
      in1_pready  = 1'b0;
      in1_prdata  = 32'h0;
      in1_pslverr = 1'b0;
      if (w_done) begin
         if (r_grantId) begin
            in1_pready  = 1'b1;
            in1_prdata  = w_rspData;
            in1_pslverr = w_rspErr;
         end else begin
            in0_pready  = 1'b1;
            in0_prdata  = w_rspData;
            in0_pslverr = w_rspErr;
         end
      end
   end

endmodule
